// File: rtl/link_train_ctrl.sv
// Sideband link-training sequencer: walks CLD -> WAIT_RX -> TS1 -> TS2 -> CL0,
// counts failed attempts and parks in DISABLED once the retry budget is spent.
module link_train_ctrl #(
   parameter int MAX_RETRY = 3
) (
   input  logic       sb_clk,
   input  logic       rst,
   input  logic       disable_req,
   input  logic       enable_req,
   input  logic       ts1_done,
   input  logic       ts2_done,
   input  logic       tdisconnect_tx_min,
   input  logic       tdisconnect_rx_min,
   input  logic       tconnect_rx_min,
   input  logic       tdisabled_min,
   input  logic       ttraining_error_timeout,
   input  logic       tgen4_ts1_timeout,
   input  logic       tgen4_ts2_timeout,
   output logic       disconnected_s,
   output logic       fsm_disabled,
   output logic       fsm_training,
   output logic       ts1_gen4_s,
   output logic       ts2_gen4_s,
   output logic       link_up,
   output logic       train_fail,
   output logic [1:0] retry_cnt,
   output logic [2:0] state
);

   // state    | meaning
   // CLD      | disconnected, waiting for tx-disconnect minimum time
   // WAIT_RX  | waiting for the partner's rx-connect minimum time
   // TS1      | exchanging TS1 ordered sets
   // TS2      | exchanging TS2 ordered sets
   // CL0      | link up
   // DISABLED | parked until enabled after the disabled minimum time
   typedef enum logic [2:0] {
      CLD      = 3'd0,
      WAIT_RX  = 3'd1,
      TS1      = 3'd2,
      TS2      = 3'd3,
      CL0      = 3'd4,
      DISABLED = 3'd5
   } state_t;

   localparam logic [1:0] RETRY_LAST = 2'(MAX_RETRY - 1);

   state_t     state_q, state_d;
   logic [1:0] retry_cnt_q, retry_cnt_d;
   logic       train_fail_q, train_fail_d;
   logic       dis_min_seen_q, dis_min_seen_d;
   logic       ts1_fail, ts2_fail;

   assign ts1_fail = tgen4_ts1_timeout | ttraining_error_timeout;
   assign ts2_fail = tgen4_ts2_timeout | ttraining_error_timeout;

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_q        <= CLD;
         retry_cnt_q    <= 2'd0;
         train_fail_q   <= 1'b0;
         dis_min_seen_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         retry_cnt_q    <= retry_cnt_d;
         train_fail_q   <= train_fail_d;
         dis_min_seen_q <= dis_min_seen_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      retry_cnt_d    = retry_cnt_q;
      train_fail_d   = 1'b0;
      dis_min_seen_d = dis_min_seen_q;

      if (disable_req) begin
         state_d = DISABLED;
         if (state_q != DISABLED) dis_min_seen_d = 1'b0;
      end else begin
         case (state_q)
            CLD:     if (tdisconnect_tx_min) state_d = WAIT_RX;
            WAIT_RX: if (tconnect_rx_min)    state_d = TS1;
            TS1, TS2: begin
               if (tdisconnect_rx_min) begin
                  state_d = CLD;
               end else if ((state_q == TS1) ? ts1_fail : ts2_fail) begin
                  train_fail_d = 1'b1;
                  if (retry_cnt_q == RETRY_LAST) begin
                     state_d        = DISABLED;
                     retry_cnt_d    = 2'd0;
                     dis_min_seen_d = 1'b0;
                  end else begin
                     state_d = CLD;
                     if (retry_cnt_q != 2'd3) retry_cnt_d = retry_cnt_q + 2'd1;
                  end
               end else if (state_q == TS1 && ts1_done) begin
                  state_d = TS2;
               end else if (state_q == TS2 && ts2_done) begin
                  state_d     = CL0;
                  retry_cnt_d = 2'd0;
               end
            end
            CL0:     if (tdisconnect_rx_min) state_d = CLD;
            DISABLED: begin
               if (tdisabled_min) dis_min_seen_d = 1'b1;
               if ((dis_min_seen_q || tdisabled_min) && enable_req) begin
                  state_d        = CLD;
                  retry_cnt_d    = 2'd0;
                  dis_min_seen_d = 1'b0;
               end
            end
            default: state_d = CLD;
         endcase
      end
   end

   assign state          = state_q;
   assign retry_cnt      = retry_cnt_q;
   assign train_fail     = train_fail_q;
   assign disconnected_s = (state_q == CLD);
   assign fsm_disabled   = (state_q == DISABLED);
   assign ts1_gen4_s     = (state_q == TS1);
   assign ts2_gen4_s     = (state_q == TS2);
   assign fsm_training   = (state_q == TS1) || (state_q == TS2);
   assign link_up        = (state_q == CL0);

endmodule

// File: tb/tb_link_train_ctrl.sv
// Scripted scoreboard bench for link_train_ctrl: each step queues the expected
// state/retry/fail triple, and the post-edge sample pops and compares it.
`timescale 1ns/1ps
module tb_link_train_ctrl;

   localparam int DIS   = 1 << 0;
   localparam int EN    = 1 << 1;
   localparam int TS1D  = 1 << 2;
   localparam int TS2D  = 1 << 3;
   localparam int TXMIN = 1 << 4;
   localparam int RXMIN = 1 << 5;
   localparam int CONN  = 1 << 6;
   localparam int DMIN  = 1 << 7;
   localparam int TERR  = 1 << 8;
   localparam int TS1TO = 1 << 9;
   localparam int TS2TO = 1 << 10;

   typedef struct {
      string    tag;
      int       st;
      int       rc;
      int       tf;
   } exp_t;

   logic       sb_clk = 1'b0;
   logic       rst = 1'b0;
   logic       disable_req = 1'b0, enable_req = 1'b0, ts1_done = 1'b0, ts2_done = 1'b0;
   logic       tdisconnect_tx_min = 1'b0, tdisconnect_rx_min = 1'b0, tconnect_rx_min = 1'b0;
   logic       tdisabled_min = 1'b0, ttraining_error_timeout = 1'b0;
   logic       tgen4_ts1_timeout = 1'b0, tgen4_ts2_timeout = 1'b0;
   logic       disconnected_s, fsm_disabled, fsm_training, ts1_gen4_s, ts2_gen4_s;
   logic       link_up, train_fail;
   logic [1:0] retry_cnt;
   logic [2:0] state;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   link_train_ctrl #(.MAX_RETRY(3)) dut (
      .sb_clk(sb_clk), .rst(rst),
      .disable_req(disable_req), .enable_req(enable_req),
      .ts1_done(ts1_done), .ts2_done(ts2_done),
      .tdisconnect_tx_min(tdisconnect_tx_min), .tdisconnect_rx_min(tdisconnect_rx_min),
      .tconnect_rx_min(tconnect_rx_min), .tdisabled_min(tdisabled_min),
      .ttraining_error_timeout(ttraining_error_timeout),
      .tgen4_ts1_timeout(tgen4_ts1_timeout), .tgen4_ts2_timeout(tgen4_ts2_timeout),
      .disconnected_s(disconnected_s), .fsm_disabled(fsm_disabled),
      .fsm_training(fsm_training), .ts1_gen4_s(ts1_gen4_s), .ts2_gen4_s(ts2_gen4_s),
      .link_up(link_up), .train_fail(train_fail), .retry_cnt(retry_cnt), .state(state)
   );

   always #5 sb_clk = ~sb_clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int v);
      disable_req             = (v & DIS)   != 0;
      enable_req              = (v & EN)    != 0;
      ts1_done                = (v & TS1D)  != 0;
      ts2_done                = (v & TS2D)  != 0;
      tdisconnect_tx_min      = (v & TXMIN) != 0;
      tdisconnect_rx_min      = (v & RXMIN) != 0;
      tconnect_rx_min         = (v & CONN)  != 0;
      tdisabled_min           = (v & DMIN)  != 0;
      ttraining_error_timeout = (v & TERR)  != 0;
      tgen4_ts1_timeout       = (v & TS1TO) != 0;
      tgen4_ts2_timeout       = (v & TS2TO) != 0;
   endtask

   // Compare every output against the expected state, retry count and fail pulse.
   task automatic compare_outputs(input exp_t e);
      check({e.tag, ".state"},      int'(state),          e.st);
      check({e.tag, ".retry"},      int'(retry_cnt),      e.rc);
      check({e.tag, ".fail"},       int'(train_fail),     e.tf);
      check({e.tag, ".link_up"},    int'(link_up),        int'(e.st == 4));
      check({e.tag, ".disconn"},    int'(disconnected_s), int'(e.st == 0));
      check({e.tag, ".disabled"},   int'(fsm_disabled),   int'(e.st == 5));
      check({e.tag, ".training"},   int'(fsm_training),   int'(e.st == 2 || e.st == 3));
      check({e.tag, ".ts1"},        int'(ts1_gen4_s),     int'(e.st == 2));
      check({e.tag, ".ts2"},        int'(ts2_gen4_s),     int'(e.st == 3));
   endtask

   task automatic step(input string tag, input int v, input int st, input int rc, input int tf);
      exp_t e;
      drive(v);
      e.tag = tag; e.st = st; e.rc = rc; e.tf = tf;
      sb_q.push_back(e);
      @(posedge sb_clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, ".sb_empty"}, 0, 1);
      end else begin
         e = sb_q.pop_front();
         compare_outputs(e);
      end
      drive(0);
   endtask

   initial begin
      exp_t r;
      // reset state
      #3;
      r.tag = "reset"; r.st = 0; r.rc = 0; r.tf = 0;
      compare_outputs(r);
      @(negedge sb_clk);
      rst = 1'b1;

      // nominal bring-up
      step("up_cld",  0,     0, 0, 0);
      step("up_wait", TXMIN, 1, 0, 0);
      step("up_ts1",  CONN,  2, 0, 0);
      step("up_ts2",  TS1D,  3, 0, 0);
      step("up_cl0",  TS2D,  4, 0, 0);
      step("cl0_hold", 0,    4, 0, 0);

      // partner disconnect from CL0
      step("cl0_rx_disc", RXMIN, 0, 0, 0);

      // three TS1 timeouts exhaust the retry budget
      step("r1_wait", TXMIN, 1, 0, 0);
      step("r1_ts1",  CONN,  2, 0, 0);
      step("r1_to",   TS1TO, 0, 1, 1);
      step("r2_wait", TXMIN, 1, 1, 0);
      step("r2_ts1",  CONN,  2, 1, 0);
      step("r2_to",   TS1TO | TS1D, 0, 2, 1);
      step("r3_wait", TXMIN, 1, 2, 0);
      step("r3_ts1",  CONN,  2, 2, 0);
      step("r3_to",   TS1TO, 5, 0, 1);
      step("dis_idle", 0,    5, 0, 0);

      // enable without minimum time stays parked, then exit with tdisabled_min
      step("dis_en1", EN,        5, 0, 0);
      step("dis_en2", EN,        5, 0, 0);
      step("dis_exit", EN | DMIN, 0, 0, 0);

      // disable request during TS1, then exit via remembered minimum time
      step("d_wait",  TXMIN, 1, 0, 0);
      step("d_ts1",   CONN,  2, 0, 0);
      step("d_req",   DIS | TS1D, 5, 0, 0);
      step("d_min",   DMIN,  5, 0, 0);
      step("d_blk",   DIS | EN, 5, 0, 0);
      step("d_exit",  EN,    0, 0, 0);

      // done and timeout together in TS2: timeout wins
      step("c_wait",  TXMIN, 1, 0, 0);
      step("c_ts1",   CONN,  2, 0, 0);
      step("c_ts2",   TS1D,  3, 0, 0);
      step("c_coll",  TS2D | TS2TO, 0, 1, 0 + 1);

      // rx disconnect outranks timeout, retry kept
      step("x_wait",  TXMIN, 1, 1, 0);
      step("x_ts1",   CONN,  2, 1, 0);
      step("x_rx",    RXMIN | TERR | TS1D, 0, 1, 0);

      // reaching CL0 clears retry
      step("k_wait",  TXMIN, 1, 1, 0);
      step("k_ts1",   CONN,  2, 1, 0);
      step("k_ts2",   TS1D,  3, 1, 0);
      step("k_cl0",   TS2D,  4, 0, 0);

      // async reset mid-TS2 with a timeout pending
      step("a_rx",    RXMIN, 0, 0, 0);
      step("a_wait",  TXMIN, 1, 0, 0);
      step("a_ts1",   CONN,  2, 0, 0);
      step("a_ts2",   TS1D,  3, 0, 0);
      drive(TS2TO);
      #2;
      rst = 1'b0;
      #1;
      r.tag = "async_rst"; r.st = 0; r.rc = 0; r.tf = 0;
      compare_outputs(r);
      @(posedge sb_clk);
      #1;
      r.tag = "rst_hold";
      compare_outputs(r);
      drive(0);
      @(negedge sb_clk);
      rst = 1'b1;
      step("post_cld",  0,     0, 0, 0);
      step("post_wait", TXMIN, 1, 0, 0);

      check("sb_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/link_train_ctrl.md
LINK_TRAIN_CTRL -- requirements
Module: link_train_ctrl

Interface
REQ-001 Parameter MAX_RETRY, default 3, failed training attempts allowed before forced DISABLED; legal range 1..3.
REQ-002 sb_clk  input  1  sideband clock (1 MHz); sole clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 disable_req  input  1  level; request to enter DISABLED.
REQ-005 enable_req  input  1  level; request to leave DISABLED.
REQ-006 ts1_done  input  1  pulse; required TS1 ordered sets received.
REQ-007 ts2_done  input  1  pulse; required TS2 ordered sets received.
REQ-008 tdisconnect_tx_min, tdisconnect_rx_min, tconnect_rx_min, tdisabled_min  input  1 each  timer minimum-time flags, already synchronous to sb_clk.
REQ-009 ttraining_error_timeout, tgen4_ts1_timeout, tgen4_ts2_timeout  input  1 each  timer timeout flags, synchronous to sb_clk.
REQ-010 disconnected_s  output  1  high in CLD; drives timer tx-disconnect counter.
REQ-011 fsm_disabled  output  1  high in DISABLED.
REQ-012 fsm_training  output  1  high in TS1 and TS2.
REQ-013 ts1_gen4_s / ts2_gen4_s  output  1 each  high in TS1 / TS2 respectively.
REQ-014 link_up  output  1  high in CL0.
REQ-015 train_fail  output  1  one-cycle pulse per failed attempt.
REQ-016 retry_cnt  output  2  failed attempts since last CL0 or DISABLED exit.
REQ-017 state  output  3  encoding CLD=0, WAIT_RX=1, TS1=2, TS2=3, CL0=4, DISABLED=5.

Function
REQ-018 All outputs shall be decoded from registered state/counters only; no combinational input-to-output paths.
REQ-019 disable_req=1 shall move any state to DISABLED next cycle; highest priority.
REQ-020 CLD: disconnected_s=1; tdisconnect_tx_min=1 -> WAIT_RX.
REQ-021 WAIT_RX: tconnect_rx_min=1 -> TS1.
REQ-022 TS1: ts1_done=1 -> TS2; tgen4_ts1_timeout or ttraining_error_timeout -> FAIL action.
REQ-023 TS2: ts2_done=1 -> CL0; tgen4_ts2_timeout or ttraining_error_timeout -> FAIL action.
REQ-024 In TS1/TS2 simultaneous done and timeout: timeout wins (FAIL).
REQ-025 In TS1, TS2, CL0: tdisconnect_rx_min=1 -> CLD without FAIL action, retry_cnt unchanged; outranks done and timeout.
REQ-026 FAIL action: train_fail pulses 1 cycle; if retry_cnt+1 == MAX_RETRY -> DISABLED, retry_cnt cleared; else retry_cnt increments, -> CLD.
REQ-027 Entering CL0 shall clear retry_cnt the same edge.
REQ-028 DISABLED: fsm_disabled=1; internal flag dis_min_seen cleared on entry, set when tdisabled_min=1; exit to CLD when dis_min_seen (or tdisabled_min this cycle) and enable_req=1 and disable_req=0.
REQ-029 retry_cnt shall saturate, never wrap; unreachable state encodings 6,7 -> CLD next cycle.
REQ-030 Each transition shall take exactly one sb_clk edge; outputs reflect new state in the same cycle state updates.

Reset
REQ-031 rst=0 shall immediately force state=CLD, retry_cnt=0, dis_min_seen=0, train_fail=0, link_up=0, fsm_*=0, ts*_gen4_s=0, disconnected_s=1.
REQ-032 Reset asserted mid-training shall abort without train_fail pulse; release resumes from CLD.

Verification
REQ-033 Release reset, pulse tdisconnect_tx_min, tconnect_rx_min, ts1_done, ts2_done on successive cycles -> state 0,1,2,3,4; link_up=1 after 4th edge, retry_cnt=0.
REQ-034 In TS1 pulse tgen4_ts1_timeout three times (retraining between) with MAX_RETRY=3 -> train_fail 3 pulses, retry_cnt 1,2 then 0, state=5, fsm_disabled=1.
REQ-035 In TS2 assert ts2_done and tgen4_ts2_timeout same cycle -> FAIL, state=CLD, retry_cnt=1, link_up stays 0.
REQ-036 In CL0 pulse tdisconnect_rx_min -> state=CLD, no train_fail, retry_cnt=0.
REQ-037 In DISABLED hold enable_req=1 without tdisabled_min -> stays 5; pulse tdisabled_min -> state=CLD next edge; disable_req=1 in TS1 -> state=5 next edge.
REQ-038 Assert rst=0 asynchronously while in TS2 -> state=0, disconnected_s=1 before next edge, no train_fail.
